// File: rtl/core_status_monitor_pkg.sv
// Shared definitions for the core status monitor: status codes from the core
// and the monitor state encoding.
package core_status_monitor_pkg;

   localparam logic [1:0] R_TYPE_SUCCESS = 2'd0;
   localparam logic [1:0] I_TYPE_SUCCESS = 2'd1;
   localparam logic [1:0] MIPS_OVERFLOW  = 2'd2;
   localparam logic [1:0] MIPS_END       = 2'd3;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } mon_state_e;

   // Both terminal codes share the upper bit.
   function automatic logic is_terminal(input logic [1:0] code);
      return code[1];
   endfunction

endpackage

// File: rtl/core_status_monitor_trace_fifo.sv
// Trace FIFO for the status monitor: register array with wrap-around pointers
// carrying one extra bit to tell full from empty.
module status_trace_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop   = pop && !empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + (AW+1)'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/core_status_monitor.sv
// Receiving end of the core status interface: counts R/I completions, latches
// the first terminal status and records a per-instruction trace.
//
// state | meaning
// RUN   | sampling status words, counting and tracing
// DONE  | terminal status latched, all further samples ignored
module core_status_monitor
   import core_status_monitor_pkg::*;
#(
   parameter int CNT_W      = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [1:0]         i_status,
   input  logic               i_status_valid,
   output logic [CNT_W-1:0]   o_r_cnt,
   output logic [CNT_W-1:0]   o_i_cnt,
   output logic               o_done,
   output logic [1:0]         o_final_status,
   output logic               o_trace_valid,
   output logic [CNT_W+1:0]   o_trace_data,
   input  logic               i_trace_ready,
   output logic               o_trace_drop
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   mon_state_e       state_q;
   mon_state_e       state_d;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] i_cnt;
   logic [CNT_W-1:0] idx;
   logic [1:0]       final_q;
   logic             drop_q;
   logic             sample;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;

   assign sample   = i_status_valid && (state_q == ST_RUN);
   // Sum of the already-saturated counters, truncated to the index width.
   assign idx      = r_cnt + i_cnt;
   assign fifo_pop = !fifo_empty && i_trace_ready;

   always_comb begin
      state_d = state_q;
      if (sample && is_terminal(i_status)) state_d = ST_DONE;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_RUN;
         r_cnt   <= '0;
         i_cnt   <= '0;
         final_q <= 2'd0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (sample) begin
            case (i_status)
               R_TYPE_SUCCESS: if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
               I_TYPE_SUCCESS: if (i_cnt != CNT_MAX) i_cnt <= i_cnt + 1'b1;
               default:        final_q <= i_status;
            endcase
            if (fifo_full && !fifo_pop) drop_q <= 1'b1;
         end
      end
   end

   status_trace_fifo #(
      .WIDTH (CNT_W + 2),
      .DEPTH (FIFO_DEPTH)
   ) u_trace_fifo (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .push      (sample),
      .push_data ({idx, i_status}),
      .full      (fifo_full),
      .pop       (fifo_pop),
      .pop_data  (o_trace_data),
      .empty     (fifo_empty)
   );

   assign o_r_cnt        = r_cnt;
   assign o_i_cnt        = i_cnt;
   assign o_done         = (state_q == ST_DONE);
   assign o_final_status = final_q;
   assign o_trace_valid  = !fifo_empty;
   assign o_trace_drop   = drop_q;

endmodule

// File: tb/tb_core_status_monitor.sv
// Bench for core_status_monitor: table vectors, directed corner sequences and
// random traffic compared against a queue-based reference model.
module tb_core_status_monitor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  s;
   logic        v;
   logic        rd;
   logic [15:0] r_cnt, i_cnt;
   logic        done, tvalid, drop;
   logic [1:0]  fin;
   logic [17:0] tdata;

   logic [1:0]  s4;
   logic        v4, rd4;
   logic [3:0]  r4, i4;
   logic        done4, tv4, drop4;
   logic [1:0]  fin4;
   logic [5:0]  td4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   core_status_monitor #(.CNT_W(16), .FIFO_DEPTH(8)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_status(s), .i_status_valid(v),
      .o_r_cnt(r_cnt), .o_i_cnt(i_cnt), .o_done(done), .o_final_status(fin),
      .o_trace_valid(tvalid), .o_trace_data(tdata), .i_trace_ready(rd),
      .o_trace_drop(drop)
   );

   core_status_monitor #(.CNT_W(4), .FIFO_DEPTH(8)) dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_status(s4), .i_status_valid(v4),
      .o_r_cnt(r4), .o_i_cnt(i4), .o_done(done4), .o_final_status(fin4),
      .o_trace_valid(tv4), .o_trace_data(td4), .i_trace_ready(rd4),
      .o_trace_drop(drop4)
   );

   // Reference model: plain counters plus a queue standing in for the trace FIFO.
   int unsigned m_r, m_i;
   bit          m_done, m_drop;
   logic [1:0]  m_final;
   logic [17:0] m_q[$];
   logic [17:0] got_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_r = 0; m_i = 0; m_done = 0; m_drop = 0; m_final = 2'd0;
      m_q.delete();
   endtask

   task automatic model_step(input logic vv, input logic [1:0] ss, input logic rr);
      bit          pop_now;
      bit          push_now;
      logic [17:0] e;
      pop_now  = (m_q.size() > 0) && rr;
      push_now = 0;
      e        = '0;
      if (vv && !m_done) begin
         e        = {16'((m_r + m_i) % 65536), ss};
         push_now = 1;
         if (ss == 2'd0)      m_r = (m_r == 65535) ? m_r : m_r + 1;
         else if (ss == 2'd1) m_i = (m_i == 65535) ? m_i : m_i + 1;
         else begin
            m_done  = 1;
            m_final = ss;
         end
      end
      if (pop_now) void'(m_q.pop_front());
      if (push_now) begin
         if (m_q.size() < 8) m_q.push_back(e);
         else m_drop = 1;
      end
   endtask

   task automatic compare_model();
      check("model r_cnt", 32'(r_cnt), m_r);
      check("model i_cnt", 32'(i_cnt), m_i);
      check("model done", 32'(done), 32'(m_done));
      check("model final", 32'(fin), 32'(m_final));
      check("model drop", 32'(drop), 32'(m_drop));
      check("model tvalid", 32'(tvalid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) check("model tdata", 32'(tdata), 32'(m_q[0]));
   endtask

   task automatic step(input logic vv, input logic [1:0] ss, input logic rr);
      v = vv; s = ss; rd = rr;
      @(posedge clk);
      model_step(vv, ss, rr);
      #1;
      compare_model();
   endtask

   task automatic do_reset();
      v = 0; s = 0; rd = 0; v4 = 0; s4 = 0; rd4 = 0;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("rst r_cnt", 32'(r_cnt), 32'd0);
      check("rst i_cnt", 32'(i_cnt), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst final", 32'(fin), 32'd0);
      check("rst tvalid", 32'(tvalid), 32'd0);
      check("rst tdata", 32'(tdata), 32'd0);
      check("rst drop", 32'(drop), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic drain();
      got_q.delete();
      for (int k = 0; k < 20; k++) begin
         if (!tvalid) break;
         got_q.push_back(tdata);
         step(1'b0, 2'd0, 1'b1);
      end
   endtask

   typedef struct {
      logic        v;
      logic [1:0]  s;
      logic        rd;
      int          r;
      int          i;
      logic        done;
      logic [1:0]  fin;
      logic        tv;
      logic [17:0] td;
      logic        drop;
   } vec_t;

   vec_t        vt[6];
   logic [17:0] exp1[5];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b1;
      v = 0; s = 0; rd = 0; v4 = 0; s4 = 0; rd4 = 0;
      model_reset();
      #2;
      do_reset();

      // I, OVERFLOW, then a trailing R that must be ignored; drained afterwards.
      vt[0] = '{1'b1, 2'd1, 1'b0, 0, 1, 1'b0, 2'd0, 1'b1, 18'h1, 1'b0};
      vt[1] = '{1'b1, 2'd2, 1'b0, 0, 1, 1'b1, 2'd2, 1'b1, 18'h1, 1'b0};
      vt[2] = '{1'b1, 2'd0, 1'b0, 0, 1, 1'b1, 2'd2, 1'b1, 18'h1, 1'b0};
      vt[3] = '{1'b0, 2'd0, 1'b1, 0, 1, 1'b1, 2'd2, 1'b1, 18'h6, 1'b0};
      vt[4] = '{1'b0, 2'd0, 1'b1, 0, 1, 1'b1, 2'd2, 1'b0, 18'h0, 1'b0};
      vt[5] = '{1'b1, 2'd3, 1'b1, 0, 1, 1'b1, 2'd2, 1'b0, 18'h0, 1'b0};
      for (int k = 0; k < 6; k++) begin
         step(vt[k].v, vt[k].s, vt[k].rd);
         check("vec r_cnt", 32'(r_cnt), 32'(vt[k].r));
         check("vec i_cnt", 32'(i_cnt), 32'(vt[k].i));
         check("vec done", 32'(done), 32'(vt[k].done));
         check("vec final", 32'(fin), 32'(vt[k].fin));
         check("vec tvalid", 32'(tvalid), 32'(vt[k].tv));
         if (vt[k].tv) check("vec tdata", 32'(tdata), 32'(vt[k].td));
         check("vec drop", 32'(drop), 32'(vt[k].drop));
      end

      // R,I,R,R every other cycle, then END held valid for 10 cycles.
      do_reset();
      step(1, 2'd0, 0); step(0, 2'd0, 0);
      step(1, 2'd1, 0); step(0, 2'd1, 0);
      step(1, 2'd0, 0); step(0, 2'd3, 0);
      step(1, 2'd0, 0); step(0, 2'd2, 0);
      for (int k = 0; k < 10; k++) step(1, 2'd3, 0);
      check("t1 r_cnt", 32'(r_cnt), 32'd3);
      check("t1 i_cnt", 32'(i_cnt), 32'd1);
      check("t1 final", 32'(fin), 32'd3);
      check("t1 done", 32'(done), 32'd1);
      exp1[0] = {16'd0, 2'd0}; exp1[1] = {16'd1, 2'd1}; exp1[2] = {16'd2, 2'd0};
      exp1[3] = {16'd3, 2'd0}; exp1[4] = {16'd4, 2'd3};
      drain();
      check("t1 trace count", 32'(got_q.size()), 32'd5);
      for (int k = 0; k < 5; k++)
         if (k < got_q.size()) check("t1 trace entry", 32'(got_q[k]), 32'(exp1[k]));

      // Overfill with reader stalled, then drain in order.
      do_reset();
      for (int k = 0; k < 10; k++) step(1, 2'd0, 0);
      check("t3 drop", 32'(drop), 32'd1);
      check("t3 r_cnt", 32'(r_cnt), 32'd10);
      drain();
      check("t3 trace count", 32'(got_q.size()), 32'd8);
      for (int k = 0; k < 8; k++)
         if (k < got_q.size()) check("t3 trace entry", 32'(got_q[k]), 32'(k * 4));
      check("t3 empty after drain", 32'(tvalid), 32'd0);

      // Full FIFO with simultaneous push and pop.
      do_reset();
      for (int k = 0; k < 8; k++) step(1, 2'd0, 0);
      check("t4 head before", 32'(tdata), 32'h0);
      check("t4 drop before", 32'(drop), 32'd0);
      step(1, 2'd0, 1);
      check("t4 drop after", 32'(drop), 32'd0);
      check("t4 head after", 32'(tdata), 32'(18'h4));
      drain();
      check("t4 trace count", 32'(got_q.size()), 32'd8);
      if (got_q.size() == 8) check("t4 last entry", 32'(got_q[7]), 32'(18'h20));

      // Narrow counters saturate; trace index follows the saturated count.
      do_reset();
      got_q.delete();
      for (int k = 0; k < 18; k++) begin
         v4 = (k < 17); s4 = 2'd0; rd4 = 1'b1;
         if (tv4) got_q.push_back(18'(td4));
         @(posedge clk);
         #1;
      end
      v4 = 0; rd4 = 0;
      check("t5 r_cnt", 32'(r4), 32'd15);
      check("t5 trace count", 32'(got_q.size()), 32'd17);
      if (got_q.size() == 17) begin
         check("t5 idx first", 32'(got_q[0][5:2]), 32'd0);
         check("t5 idx 14", 32'(got_q[14][5:2]), 32'd14);
         check("t5 idx 15", 32'(got_q[15][5:2]), 32'd15);
         check("t5 idx last", 32'(got_q[16][5:2]), 32'd15);
      end
      check("t5 drop", 32'(drop4), 32'd0);
      check("t5 empty", 32'(tv4), 32'd0);

      // Reset in the middle of a run, then resume with I.
      do_reset();
      step(1, 2'd0, 0); step(1, 2'd1, 0); step(1, 2'd0, 0);
      do_reset();
      step(1, 2'd1, 0);
      check("t6 i_cnt", 32'(i_cnt), 32'd1);
      check("t6 r_cnt", 32'(r_cnt), 32'd0);
      check("t6 tvalid", 32'(tvalid), 32'd1);
      check("t6 tdata", 32'(tdata), 32'(18'h1));

      // Random traffic against the model, with occasional resets.
      do_reset();
      for (int k = 0; k < 800; k++) begin
         logic       rv, rr;
         logic [1:0] rs;
         if ($urandom_range(0, 149) == 0) do_reset();
         rv = ($urandom_range(0, 2) != 0);
         rs = ($urandom_range(0, 39) == 0) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1));
         rr = ($urandom_range(0, 2) == 0);
         step(rv, rs, rr);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
